// File: rtl/dmem_pkg.sv
// ==== dmem_pkg : shared types and lane helpers for the data memory LSU (rev 1.0) ====
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Byte-enable mask for an access of the given size starting at a byte offset within the word.
    function automatic logic [7:0] lane_strobe(input logic [2:0] offset, input size_e size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << offset;
    endfunction

    function automatic logic [63:0] load_align(input logic [63:0] word,
                                               input logic [2:0]  offset,
                                               input size_e       size,
                                               input logic        is_unsigned);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {offset, 3'b000};
        case (size)
            SZ_B:    res = is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SZ_H:    res = is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    res = is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// ==== dmem_ram : single-port word array with per-byte write strobes (rev 1.0) ====
`default_nettype none

module dmem_ram #(
    parameter int ADDR_W     = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      wr_en_i,
    input  logic [DATA_WIDTH/8-1:0]   strb_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // The LSU captures the read word on the accept edge, so an asynchronous read port suffices.
    assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
// ==== dmem_lsu : RISC-V data memory with valid/ready load/store front end (rev 1.0) ====
// Option: define DMEM_CLEAR_ON_RESET_EN to zero the whole array, one word per cycle, after reset.
`default_nettype none

module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int AW    = ADDR_WIDTH - OFF_W;
    localparam int DEPTH = 2**AW;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] pend_rdata_q;
    logic                  pend_err_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    size_e                 w_size;
    logic                  w_uns;
    logic [OFF_W-1:0]      w_off;
    logic                  w_misaligned;
    logic                  w_illegal;
    logic                  w_err;
    logic                  w_accept;
    logic [NB-1:0]         w_strb;
    logic [DATA_WIDTH-1:0] w_wdata_rep;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    logic                  w_ram_we;
    logic [NB-1:0]         w_ram_strb;
    logic [AW-1:0]         w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_size      = size_e'(req_funct3_i[1:0]);
    assign w_uns       = req_funct3_i[2];
    assign w_off       = req_addr_i[OFF_W-1:0];
    assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
    assign w_accept    = req_valid_i && req_ready_o;

    always_comb begin
        w_misaligned = 1'b0;
        case (w_size)
            SZ_H:    w_misaligned = req_addr_i[0];
            SZ_W:    w_misaligned = |req_addr_i[1:0];
            SZ_D:    w_misaligned = |req_addr_i[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // Double accesses only exist on a 64-bit array; "unsigned" has no meaning for stores.
    assign w_illegal = ((w_size == SZ_D) && (DATA_WIDTH < 64)) || (req_we_i && w_uns);
    assign w_err     = w_misaligned || w_illegal;

    always_comb begin
        w_strb = NB'(lane_strobe(3'(w_off), w_size));
    end

    always_comb begin
        w_wdata_rep = req_wdata_i;
        for (int i = 0; i < NB; i++) begin
            case (w_size)
                SZ_B:    w_wdata_rep[i*8 +: 8] = req_wdata_i[7:0];
                SZ_H:    w_wdata_rep[i*8 +: 8] = req_wdata_i[(i % 2)*8 +: 8];
                SZ_W:    w_wdata_rep[i*8 +: 8] = req_wdata_i[(i % 4)*8 +: 8];
                default: w_wdata_rep[i*8 +: 8] = req_wdata_i[i*8 +: 8];
            endcase
        end
    end

    always_comb begin
        w_load_data = DATA_WIDTH'(load_align(64'(w_ram_rdata), 3'(w_off), w_size, w_uns));
        w_rsp_data  = (req_we_i || w_err) ? '0 : w_load_data;
    end

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam state_e RESET_STATE = CLEAR;

    logic [AW-1:0] clr_idx_q;
    logic          w_clearing;

    assign w_clearing  = (state_q == CLEAR);
    assign w_ram_we    = w_clearing || (w_accept && req_we_i && !w_err);
    assign w_ram_strb  = w_clearing ? '1 : w_strb;
    assign w_ram_addr  = w_clearing ? clr_idx_q : req_addr_i[ADDR_WIDTH-1:OFF_W];
    assign w_ram_wdata = w_clearing ? '0 : w_wdata_rep;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_idx_q <= '0;
        end else if (w_clearing) begin
            clr_idx_q <= clr_idx_q + 1'b1;
        end
    end
`else
    localparam state_e RESET_STATE = IDLE;

    assign w_ram_we    = w_accept && req_we_i && !w_err;
    assign w_ram_strb  = w_strb;
    assign w_ram_addr  = req_addr_i[ADDR_WIDTH-1:OFF_W];
    assign w_ram_wdata = w_wdata_rep;
`endif

    dmem_ram #(
        .ADDR_W     (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en_i (w_ram_we),
        .strb_i  (w_ram_strb),
        .addr_i  (w_ram_addr),
        .wdata_i (w_ram_wdata),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            cnt_q        <= '0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_q <= IDLE;
                    end
`else
                    state_q <= IDLE;
`endif
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pend_rdata_q;
                        rsp_err_q   <= pend_err_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Acceptance overrides the RESP->IDLE retirement so back-to-back requests chain directly.
            if (w_accept) begin
                if (READ_LATENCY == 1) begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= w_rsp_data;
                    rsp_err_q   <= w_err;
                end else begin
                    state_q      <= WAIT;
                    cnt_q        <= CNT_INIT;
                    pend_rdata_q <= w_rsp_data;
                    pend_err_q   <= w_err;
                end
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// ==== tb_dmem_lsu : scoreboard bench for dmem_lsu (rev 1.0) ====
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_lsu;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int LAT   = 3;
    localparam int DEPTH = 1024;
`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic CLEAR_EN = 1'b1;
`else
    localparam logic CLEAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mdl [int];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    dmem_lsu #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy)
    );

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (busy && cyc < DEPTH + 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: busy=%b required 0", name, busy);
        end
    endtask

    // Waits for the response after an accept edge and checks latency and payload against the scoreboard.
    task automatic collect(input string name);
        exp_t e;
        int   lat;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        vectors++;
        if (lat != LAT || rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles valid=%b required %0d", name, lat, rsp_valid, LAT);
        end
        vectors++;
        if (rsp_rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL %s rdata: got %h required %h", name, rsp_rdata, e.rdata);
        end
        vectors++;
        if (rsp_err !== e.err) begin
            miscompares++;
            $display("FAIL %s err: got %b required %b", name, rsp_err, e.err);
        end
    endtask

    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input string name);
        int cyc;
        sb_q.push_back('{rdata: exp_rd, err: exp_err});
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b1;
        #1;
        cyc = 0;
        while (!req_ready && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        collect(name);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || busy !== CLEAR_EN) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b rdata=%h err=%b busy=%b required 0 0 0 %b",
                     rsp_valid, rsp_rdata, rsp_err, busy, CLEAR_EN);
        end
        reset = 1'b0;
        wait_idle("reset");
    endtask

    task automatic test_load_store();
        do_txn(1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h0,        1'b0, "sw_dead");
        do_txn(1'b0, 3'b010, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0, "lw_dead");
        do_txn(1'b1, 3'b010, 12'h010, 32'h0,        32'h0,        1'b0, "sw_zero");
        do_txn(1'b1, 3'b000, 12'h011, 32'h80,       32'h0,        1'b0, "sb_80");
        do_txn(1'b0, 3'b000, 12'h011, 32'h0,        32'hFFFFFF80, 1'b0, "lb");
        do_txn(1'b0, 3'b100, 12'h011, 32'h0,        32'h00000080, 1'b0, "lbu");
        do_txn(1'b0, 3'b010, 12'h010, 32'h0,        32'h00008000, 1'b0, "lw_after_sb");
        do_txn(1'b1, 3'b001, 12'h016, 32'h12349ABC, 32'h0,        1'b0, "sh");
        do_txn(1'b0, 3'b001, 12'h016, 32'h0,        32'hFFFF9ABC, 1'b0, "lh");
        do_txn(1'b0, 3'b101, 12'h016, 32'h0,        32'h00009ABC, 1'b0, "lhu");
    endtask

    task automatic test_errors();
        do_txn(1'b0, 3'b001, 12'h013, 32'h0,        32'h0, 1'b1, "lh_misaligned");
        do_txn(1'b1, 3'b010, 12'h012, 32'hFFFFFFFF, 32'h0, 1'b1, "sw_misaligned");
        do_txn(1'b0, 3'b011, 12'h010, 32'h0,        32'h0, 1'b1, "ld_illegal");
        do_txn(1'b1, 3'b100, 12'h010, 32'hFFFFFFFF, 32'h0, 1'b1, "store_unsigned");
        do_txn(1'b0, 3'b010, 12'h010, 32'h0,        32'h00008000, 1'b0, "lw_unchanged");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        sb_q.push_back('{rdata: 32'h00008000, err: 1'b0});
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 12'h010; rsp_ready = 1'b0;
        #1;
        cyc = 0;
        while (!req_ready && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
            end
            @(negedge clk); #1;
        end
        sb_q.push_back('{rdata: 32'h00000080, err: 1'b0});
        req_valid = 1'b1; req_funct3 = 3'b100; req_addr = 12'h011; rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        collect("b2b_lbu");
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 12'h010; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== CLEAR_EN || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wait_state: busy=%b valid=%b required %b 0", busy, rsp_valid, CLEAR_EN);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk); #1;
            seen = seen | rsp_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wait_dropped: rsp_valid seen=%b required 0", seen);
        end
        wait_idle("reset_wait");
        do_txn(1'b0, 3'b010, 12'h010, 32'h0, CLEAR_EN ? 32'h0 : 32'h00008000, 1'b0, "lw_after_reset");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [31:0]   wd;
        logic [31:0]   v;
        logic [1:0]    sz;
        logic          we;
        logic          uns;
        int            n;
        for (int w = 0; w < 16; w++) begin
            do_txn(1'b1, 3'b010, AW'(12'h100 + 4*w), 32'h0, 32'h0, 1'b0, "rnd_init");
            for (int k = 0; k < 4; k++) mdl[12'h100 + 4*w + k] = 8'h00;
        end
        for (int t = 0; t < 24; t++) begin
            sz  = 2'($urandom_range(0, 2));
            n   = 1 << sz;
            a   = AW'(12'h100 + ($urandom_range(0, 63) & ~(n - 1)));
            we  = 1'($urandom_range(0, 1));
            uns = we ? 1'b0 : 1'($urandom_range(0, 1));
            wd  = $urandom;
            v   = 32'h0;
            if (we) begin
                for (int k = 0; k < n; k++) mdl[int'(a) + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) v = v | (32'(mdl[int'(a) + k]) << (8*k));
                if (!uns && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
            end
            do_txn(we, {uns, sz}, a, wd, v, 1'b0, "rnd");
        end
    endtask

    task automatic test_clear();
        int cyc;
        do_txn(1'b1, 3'b010, 12'h020, 32'h00001234, 32'h0, 1'b0, "sw_1234");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        cyc = 0;
        while (busy && cyc < DEPTH + 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        vectors++;
        if (cyc != (CLEAR_EN ? DEPTH : 0)) begin
            miscompares++;
            $display("FAIL clear_busy_cycles: got %0d required %0d", cyc, CLEAR_EN ? DEPTH : 0);
        end
        do_txn(1'b0, 3'b010, 12'h020, 32'h0, CLEAR_EN ? 32'h0 : 32'h00001234, 1'b0, "lw_after_clear");
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_errors();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        test_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
